tc_acc: RTL and testbench
=========================

// Module: tc_acc
// PURPOSE
// Output accumulator directly downstream of the tc_rn reduction stage.
// - Sums successive N_ADT x N_STACK partial-sum tiles from the adder trees over a K-loop of any length.
// - Streams the finished tile out one row (DW_LINE) per handshake to the writeback path.
// - Frees the reduction stage from holding state across K-steps.
// PARAMETERS
// TILE_M   4                  rows per tile
// TILE_N   4                  columns per tile
// N_ADT    TILE_M             adder-tree count = output rows
// N_STACK  TILE_N             lanes per row
// DW_DATA  32                 lane width, unsigned
// DW_LINE  N_STACK*DW_DATA    row width
// PORTS
// clk        in   1               clock, rising edge
// rst        in   1               asynchronous reset, active-low (0 = reset)
// in_valid   in   1               partial-sum tile valid, aligned with tc_rn out
// in_last    in   1               final K-step of the current tile
// in         in   N_ADT*DW_LINE   partial-sum tile; row r at [r*DW_LINE +: DW_LINE]
// in_ready   out  1               accumulator accepts a tile this cycle
// out_valid  out  1               result row valid
// out_ready  in   1               downstream accepts row
// out        out  DW_LINE         result row
// out_row    out  clog2(N_ADT)    index of row on out, 0-based (min width 1)
// out_last   out  1               out_row == N_ADT-1 while out_valid
// BEHAVIOUR
// - Reset (rst=0, async): state=IDLE, acc=0, row_cnt=0.
// - Reset output values: in_ready=1, out_valid=0, out=0, out_row=0, out_last=0.
// - FSM states: IDLE (acc empty), ACC (partial sum held), DRAIN (result being read).
// - Input beat accepted when in_valid & in_ready; in_ready = (state != DRAIN).
// - IDLE:
//   - Beat: acc <= in (overwrite, no add).
//   - Next state: DRAIN if in_last, else ACC.
// - ACC:
//   - Beat: acc <= acc + in, per lane, independently.
//   - Next state: DRAIN if in_last.
//   - No beat: hold.
// - Arithmetic: each lane wraps modulo 2^DW_DATA; no saturation, no carry between lanes.
// - DRAIN:
//   - out_valid=1; out = acc row row_cnt; out_row = row_cnt.
//   - On out_valid & out_ready: row_cnt++.
//   - On the handshake with row_cnt==N_ADT-1: row_cnt <= 0, state <= IDLE, acc cleared to 0.
//   - out_ready low: out, out_row and out_valid hold stable (AXI-style, no retraction).
// - DRAIN input side: in_ready=0, so in_valid is back-pressured and any in_last is ignored.
//   - Upstream must stall the adder-tree pipeline, or size its skid to the tree latency.
// - Latency:
//   - in_last accepted at edge T -> row 0 has out_valid=1 from cycle T+1.
//   - With out_ready tied to 1, the tile drains in N_ADT cycles.
//   - Earliest next input beat is accepted in the cycle after the last row handshake.
// - Single-beat tile (in_last on first beat): out = in unchanged.
// - in_last without in_valid: no effect.
// - Reset asserted mid-ACC or mid-DRAIN: partial sum and undrained rows are discarded; FSM returns to IDLE.
// - out: driven by a mux of registered acc; no combinational path from in or in_valid to any output.
// - in_ready: depends only on state.
// TESTING
// - Reset: hold rst=0 with in_valid=1 -> in_ready=1, out_valid=0, out=0; release -> no spurious beats.
// - K=3, lane values 1,2,3 per step, all lanes; out_ready=1 -> 4 rows, each lane 6, out_row 0..3, out_last on row 3.
// - Wrap: lane 0xFFFF_FFFF + 0x0000_0002 -> lane = 0x0000_0001; adjacent lane remains unchanged.
// - Back-pressure:
//   - out_ready toggles 1,0,0,1,...; out stable while stalled; exactly 4 row handshakes.
//   - in_valid held high through DRAIN gives in_ready=0 and no accumulation.
//   - Next tile starts from 0 (IDLE overwrite).
// - Back-to-back tiles: single-beat tile A=5, then tile B=7+8 -> rows drain 5, then 15; no carry-over of A into B.
// - Reset mid-DRAIN after row 1 -> out_valid=0 at once; next tile of 9 drains as 9, row 0 first.

Source files
------------

// File: rtl/tc_acc.sv
// Output accumulator behind the tc_rn reduction stage. It sums partial-sum tiles over a K-loop of
// any length, then streams the finished tile out one row per valid/ready handshake.
module tc_acc #(
  parameter int unsigned TileM  = 4,
  parameter int unsigned TileN  = 4,
  parameter int unsigned NAdt   = TileM,
  parameter int unsigned NStack = TileN,
  parameter int unsigned DwData = 32,
  parameter int unsigned DwLine = NStack * DwData,
  localparam int unsigned RowW  = (NAdt > 1) ? $clog2(NAdt) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     in_valid_i,
  input  logic                     in_last_i,
  input  logic [NAdt*DwLine-1:0]   in_i,
  output logic                     in_ready_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [DwLine-1:0]        out_o,
  output logic [RowW-1:0]          out_row_o,
  output logic                     out_last_o
);

  typedef enum logic [1:0] {StIdle, StAcc, StDrain} state_e;

  localparam logic [RowW-1:0] LastRow = RowW'(NAdt - 1);

  state_e                        state_q, state_d;
  logic [NAdt-1:0][DwLine-1:0]   acc_q, acc_d;
  logic [RowW-1:0]               row_cnt_q, row_cnt_d;
  logic                          in_beat, out_hs, last_hs;

  // Handshake qualifiers are derived from registered state only.
  assign in_beat = in_valid_i & (state_q != StDrain);
  assign out_hs  = out_ready_i & (state_q == StDrain);
  assign last_hs = out_hs & (row_cnt_q == LastRow);

  // State, accumulator and row counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      row_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      row_cnt_q <= row_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_beat) state_d = in_last_i ? StDrain : StAcc;
      StAcc:   if (in_beat && in_last_i) state_d = StDrain;
      StDrain: if (last_hs) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Accumulator datapath: first beat overwrites, later beats add lane-wise with wrap.
  always_comb begin
    acc_d     = acc_q;
    row_cnt_d = row_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_beat) acc_d = in_i;
      end
      StAcc: begin
        if (in_beat) begin
          for (int unsigned r = 0; r < NAdt; r++) begin
            for (int unsigned l = 0; l < NStack; l++) begin
              acc_d[r][l*DwData +: DwData] = acc_q[r][l*DwData +: DwData]
                                           + in_i[r*DwLine + l*DwData +: DwData];
            end
          end
        end
      end
      StDrain: begin
        if (last_hs) begin
          acc_d     = '0;
          row_cnt_d = '0;
        end else if (out_hs) begin
          row_cnt_d = row_cnt_q + 1'b1;
        end
      end
      default: begin
        acc_d     = '0;
        row_cnt_d = '0;
      end
    endcase
  end

  // Outputs: purely from registered state, accumulator and row counter.
  always_comb begin
    in_ready_o  = (state_q != StDrain);
    out_valid_o = (state_q == StDrain);
    out_o       = acc_q[row_cnt_q];
    out_row_o   = row_cnt_q;
    out_last_o  = (state_q == StDrain) && (row_cnt_q == LastRow);
  end

endmodule

// File: tb/tb_tc_acc.sv
// Directed bench for tc_acc: reset, K-loop sums, lane wrap, back-pressure, back-to-back tiles and
// reset during drain. Inputs change 1 time unit after the rising edge; outputs are checked there.
module tb_tc_acc;

  localparam int unsigned NAdt   = 4;
  localparam int unsigned DwLine = 128;

  logic                     clk;
  logic                     rst_n;
  logic                     in_valid;
  logic                     in_last;
  logic [NAdt*DwLine-1:0]   in_tile;
  logic                     in_ready;
  logic                     out_valid;
  logic                     out_ready;
  logic [DwLine-1:0]        out_line;
  logic [1:0]               out_row;
  logic                     out_last;

  int checks = 0;
  int errors = 0;
  int hs;

  tc_acc dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_last_i   (in_last),
    .in_i        (in_tile),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_o       (out_line),
    .out_row_o   (out_row),
    .out_last_o  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DwLine-1:0] line_of(input logic [31:0] v);
    return {v, v, v, v};
  endfunction

  // Row r carries base + r*rstep in every lane.
  function automatic logic [NAdt*DwLine-1:0] tile_of(input logic [31:0] base,
                                                     input logic [31:0] rstep);
    logic [NAdt*DwLine-1:0] t;
    for (int r = 0; r < NAdt; r++) t[r*DwLine +: DwLine] = line_of(base + rstep * r);
    return t;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [NAdt*DwLine-1:0] t, input logic last);
    in_valid = 1'b1;
    in_tile  = t;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_tile  = '0;
  endtask

  // Drains a full tile with out_ready high; row r must read base + r*rstep in all lanes.
  task automatic drain_check(input string tag, input logic [31:0] base,
                             input logic [31:0] rstep);
    out_ready = 1'b1;
    for (int r = 0; r < NAdt; r++) begin
      chk({tag, "_valid"}, 128'(out_valid), 128'(1));
      chk({tag, "_ready"}, 128'(in_ready), 128'(0));
      chk({tag, "_data"}, out_line, line_of(base + rstep * r));
      chk({tag, "_row"}, 128'(out_row), 128'(r));
      chk({tag, "_last"}, 128'(out_last), 128'(r == NAdt - 1));
      step();
    end
    chk({tag, "_done_valid"}, 128'(out_valid), 128'(0));
    chk({tag, "_done_ready"}, 128'(in_ready), 128'(1));
  endtask

  initial begin
    // Reset held with in_valid high.
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_last   = 1'b1;
    in_tile   = tile_of(32'd1, 32'd0);
    out_ready = 1'b1;
    repeat (3) step();
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out", out_line, 128'(0));
    chk("rst_out_row", 128'(out_row), 128'(0));
    chk("rst_out_last", 128'(out_last), 128'(0));
    in_valid = 1'b0;
    in_last  = 1'b0;
    rst_n    = 1'b1;
    repeat (3) step();
    chk("post_rst_valid", 128'(out_valid), 128'(0));
    chk("post_rst_ready", 128'(in_ready), 128'(1));

    // K=3: 1+2+3 = 6 in every lane.
    beat(tile_of(32'd1, 32'd0), 1'b0);
    chk("k3_mid_valid", 128'(out_valid), 128'(0));
    beat(tile_of(32'd2, 32'd0), 1'b0);
    beat(tile_of(32'd3, 32'd0), 1'b1);
    drain_check("k3", 32'd6, 32'd0);

    // Lane wrap: lane0 FFFF_FFFF + 2 = 1, lane1 keeps 0x10 with no carry in.
    beat({NAdt{32'h0, 32'h0, 32'h10, 32'hFFFF_FFFF}}, 1'b0);
    beat({NAdt{32'h0, 32'h0, 32'h0, 32'h2}}, 1'b1);
    out_ready = 1'b1;
    for (int r = 0; r < NAdt; r++) begin
      chk("wrap_data", out_line, {32'h0, 32'h0, 32'h10, 32'h1});
      step();
    end
    chk("wrap_done", 128'(out_valid), 128'(0));

    // Back-pressure: rows 30+2r; in_valid stays high through drain and must not accumulate.
    beat(tile_of(32'd10, 32'd1), 1'b0);
    beat(tile_of(32'd20, 32'd1), 1'b1);
    in_valid = 1'b1;
    in_last  = 1'b1;
    in_tile  = tile_of(32'd100, 32'd0);
    hs = 0;
    for (int c = 0; c < 16; c++) begin
      out_ready = (c % 3 == 0);
      chk("bp_valid", 128'(out_valid), 128'(1));
      chk("bp_in_ready", 128'(in_ready), 128'(0));
      chk("bp_data", out_line, line_of(32'd30 + 32'd2 * hs));
      chk("bp_row", 128'(out_row), 128'(hs));
      @(posedge clk);
      if (out_ready) hs++;
      #1;
      if (hs == NAdt) break;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("bp_handshakes", 128'(hs), 128'(NAdt));
    chk("bp_done_valid", 128'(out_valid), 128'(0));
    step();
    chk("bp_idle_valid", 128'(out_valid), 128'(0));
    // Next tile overwrites from zero.
    beat(tile_of(32'd40, 32'd1), 1'b1);
    drain_check("bp_next", 32'd40, 32'd1);

    // Back-to-back: A=5 single beat, then B=7+8 starting right after the last row handshake.
    beat(tile_of(32'd5, 32'd0), 1'b1);
    drain_check("b2b_a", 32'd5, 32'd0);
    beat(tile_of(32'd7, 32'd0), 1'b0);
    beat(tile_of(32'd8, 32'd0), 1'b1);
    drain_check("b2b_b", 32'd15, 32'd0);

    // Reset after row 1 handshake: outputs drop at once; next tile drains from row 0.
    beat(tile_of(32'd50, 32'd0), 1'b1);
    out_ready = 1'b1;
    step();
    step();
    chk("mid_row", 128'(out_row), 128'(2));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_ready", 128'(in_ready), 128'(1));
    chk("mid_rst_row", 128'(out_row), 128'(0));
    chk("mid_rst_out", out_line, 128'(0));
    step();
    rst_n = 1'b1;
    step();
    beat(tile_of(32'd9, 32'd0), 1'b1);
    drain_check("after_rst", 32'd9, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
